// File: rtl/if_prefetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding word requests,
// buffers returned words in a small circular queue and drives the IF/ID register into decode.

module if_prefetch_stage_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push_i,
    input logic          pop_i,
    input logic [CW-1:0] count_i
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // a push into a full queue without a simultaneous pop would overwrite the head
    always @(negedge clk) begin
        assert (!rst_n || !(push_i && !pop_i && (count_i == DEPTH_C)))
            else $error("prefetch queue overflow");
    end
endmodule

module if_prefetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0015,
    localparam int         PW       = $clog2(DEPTH),
    localparam int         CW       = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          stall_id,
    input  logic          branch_id,
    input  logic [31:0]   branch_pc_id,
    output logic [31:0]   inst_id,
    output logic [31:0]   pc_plus_four_id,
    output logic          valid_id,
    output logic [CW-1:0] queue_count
);
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} fetch_state_e;

    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [31:0]  q_inst_q [DEPTH];
    logic [31:0]  q_pc4_q  [DEPTH];

    logic         ack_wait_s, push_s, pop_s, bypass_s, flush_s, issue_s;
    logic [CW:0]  count_after_s;
    logic [31:0]  pc_inc_s;

    assign pc_inc_s = fetch_pc_q + 32'd4;

    // next-state for fetch FSM, queue control and IF/ID register
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_d         = 1'b0;
        addr_d        = addr_q;
        inst_d        = inst_q;
        pc4_d         = pc4_q;
        valid_d       = valid_q;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        bypass_s      = 1'b0;
        flush_s       = 1'b0;
        issue_s       = 1'b0;
        ack_wait_s    = (state_q == S_WAIT) && imem_ack;
        count_after_s = {1'b0, count_q};
        if (branch_id) begin
            // redirect beats stall: kill everything on the wrong path
            flush_s    = 1'b1;
            fetch_pc_d = branch_pc_id & 32'hFFFF_FFFC;
            inst_d     = NOP_INST;
            valid_d    = 1'b0;
            if (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_ack) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            pop_s         = !stall_id && (count_q != {CW{1'b0}});
            bypass_s      = !stall_id && (count_q == {CW{1'b0}}) && ack_wait_s;
            push_s        = ack_wait_s && !bypass_s;
            count_after_s = {1'b0, count_q} + {{CW{1'b0}}, push_s} - {{CW{1'b0}}, pop_s};
            if (ack_wait_s) begin
                fetch_pc_d = pc_inc_s;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            // a returning word frees the memory port, so the next request can go out on the same edge
            issue_s = ((state_q == S_REQ) || ack_wait_s) && (count_after_s < DEPTH_W);
            if (issue_s) begin
                req_d   = 1'b1;
                addr_d  = fetch_pc_d;
                state_d = S_WAIT;
            end else if ((state_q == S_REQ) || ack_wait_s) begin
                state_d = S_REQ;
            end else if ((state_q == S_DROP) && imem_ack) begin
                state_d = S_REQ;
            end else begin
                state_d = state_q;
            end
            if (stall_id) begin
                inst_d  = inst_q;
                pc4_d   = pc4_q;
                valid_d = valid_q;
            end else if (pop_s) begin
                inst_d  = q_inst_q[head_q];
                pc4_d   = q_pc4_q[head_q];
                valid_d = 1'b1;
            end else if (bypass_s) begin
                inst_d  = imem_rdata;
                pc4_d   = pc_inc_s;
                valid_d = 1'b1;
            end else begin
                inst_d  = NOP_INST;
                pc4_d   = pc4_q;
                valid_d = 1'b0;
            end
        end
    end

    // all state moves on the falling edge, in step with the other interstage registers
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC & 32'hFFFF_FFFC;
            inst_q     <= NOP_INST;
            pc4_q      <= 32'h0000_0000;
            valid_q    <= 1'b0;
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                q_inst_q[i] <= NOP_INST;
                q_pc4_q[i]  <= 32'h0000_0000;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            if (flush_s) begin
                head_q  <= {PW{1'b0}};
                tail_q  <= {PW{1'b0}};
                count_q <= {CW{1'b0}};
            end else begin
                if (push_s) begin
                    q_inst_q[tail_q] <= imem_rdata;
                    q_pc4_q[tail_q]  <= pc_inc_s;
                    tail_q           <= tail_q + PW'(1);
                end
                if (pop_s) begin
                    head_q <= head_q + PW'(1);
                end
                count_q <= count_after_s[CW-1:0];
            end
        end
    end

    assign imem_req        = req_q;
    assign imem_addr       = addr_q;
    assign inst_id         = inst_q;
    assign pc_plus_four_id = pc4_q;
    assign valid_id        = valid_q;
    assign queue_count     = count_q;

    if_prefetch_stage_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .count_i (count_q)
    );
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: a variable-latency memory model drives two instances
// (default reset PC and one near the top of the address space).
module tb_if_prefetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0015;

    logic        clk;
    logic        rst_n, rst_w;
    logic        req, ack, stall, branch;
    logic [31:0] addr, rdata, bpc, inst, pc4;
    logic        valid;
    logic [2:0]  qcnt;
    logic        req_w, ack_w, valid_w;
    logic [31:0] addr_w, rdata_w, inst_w, pc4_w;
    logic [2:0]  qcnt_w;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat = 1;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'h0;

    if_prefetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
        .imem_rdata(rdata), .stall_id(stall), .branch_id(branch), .branch_pc_id(bpc),
        .inst_id(inst), .pc_plus_four_id(pc4), .valid_id(valid), .queue_count(qcnt)
    );

    if_prefetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_w), .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w),
        .imem_rdata(rdata_w), .stall_id(1'b0), .branch_id(1'b0), .branch_pc_id(32'h0),
        .inst_id(inst_w), .pc_plus_four_id(pc4_w), .valid_id(valid_w), .queue_count(qcnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory contents: word k (1-based) is {16'h2000+k, k}
    function automatic logic [31:0] wd(input logic [31:0] a);
        logic [31:0] k;
        k = (a >> 2) + 32'd1;
        return 32'h2000_0000 + (k << 16) + k;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // memory answers lat posedges after it sees a request (lat=1: same posedge)
    task automatic mem_step();
        ack = 1'b0;
        if (req) begin
            m_busy = 1'b1;
            m_cnt  = lat;
            m_addr = addr;
        end
        if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                ack    = 1'b1;
                rdata  = wd(m_addr);
                m_busy = 1'b0;
            end
        end
        ack_w   = req_w;
        rdata_w = wd(addr_w);
    endtask

    task automatic cycle();
        @(posedge clk);
        mem_step();
    endtask

    initial begin
        stall = 1'b0; branch = 1'b0; bpc = 32'h0; ack = 1'b0; rdata = 32'h0;
        ack_w = 1'b0; rdata_w = 32'h0;
        rst_n = 1'b1; rst_w = 1'b1;
        #1 rst_n = 1'b0; rst_w = 1'b0;
        #1;
        check_val("rst_inst", inst, NOP);
        check_val("rst_pc4", pc4, 32'h0);
        check_val("rst_valid", {31'h0, valid}, 32'h0);
        check_val("rst_count", {29'h0, qcnt}, 32'h0);
        check_val("rst_req", {31'h0, req}, 32'h0);
        cycle(); cycle();
        rst_n = 1'b1;

        // reset and stream
        cycle();
        check_val("first_req", {31'h0, req}, 32'h1);
        check_val("first_addr", addr, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_val("stream_inst", inst, wd(32'(4 * i)));
            check_val("stream_pc4", pc4, 32'(4 * i + 4));
            check_val("stream_valid", {31'h0, valid}, 32'h1);
        end

        // stall and backpressure
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_val("stall_hold", inst, wd(32'd20));
        end
        check_val("stall_count", {29'h0, qcnt}, 32'h4);
        check_val("stall_noreq", {31'h0, req}, 32'h0);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("drain_inst", inst, wd(32'(24 + 4 * i)));
            check_val("drain_pc4", pc4, 32'(28 + 4 * i));
            check_val("drain_valid", {31'h0, valid}, 32'h1);
        end

        // branch and stall together
        stall = 1'b1; branch = 1'b1; bpc = 32'h0000_0200;
        cycle();
        check_val("bs_inst", inst, NOP);
        check_val("bs_valid", {31'h0, valid}, 32'h0);
        check_val("bs_count", {29'h0, qcnt}, 32'h0);
        check_val("bs_req", {31'h0, req}, 32'h0);
        stall = 1'b0; branch = 1'b0;
        cycle();
        check_val("bs_addr", addr, 32'h0000_0200);
        check_val("bs_req2", {31'h0, req}, 32'h1);
        cycle();
        check_val("bs_tgt_inst", inst, wd(32'h200));
        check_val("bs_tgt_pc4", pc4, 32'h0000_0204);
        lat = 3;

        // redirect while waiting on a 3-cycle memory
        cycle();
        check_val("rw_pre_inst", inst, wd(32'h204));
        cycle();
        check_val("rw_gap_valid", {31'h0, valid}, 32'h0);
        branch = 1'b1; bpc = 32'h0000_0103;
        cycle();
        branch = 1'b0;
        check_val("rw_br_inst", inst, NOP);
        cycle();
        check_val("rw_drop_req", {31'h0, req}, 32'h0);
        check_val("rw_drop_count", {29'h0, qcnt}, 32'h0);
        check_val("rw_drop_valid", {31'h0, valid}, 32'h0);
        cycle();
        check_val("rw_tgt_req", {31'h0, req}, 32'h1);
        check_val("rw_tgt_addr", addr, 32'h0000_0100);
        lat = 1;
        cycle();
        check_val("rw_wait_inst", inst, NOP);
        cycle();
        check_val("rw_wait_valid", {31'h0, valid}, 32'h0);
        cycle();
        check_val("rw_tgt_inst", inst, wd(32'h100));
        check_val("rw_tgt_pc4", pc4, 32'h0000_0104);
        check_val("rw_tgt_valid", {31'h0, valid}, 32'h1);

        // async reset with three queued words and a request outstanding
        stall = 1'b1;
        cycle(); cycle(); cycle();
        check_val("ar_count", {29'h0, qcnt}, 32'h3);
        check_val("ar_req", {31'h0, req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_inst", inst, NOP);
        check_val("ar_valid", {31'h0, valid}, 32'h0);
        check_val("ar_count0", {29'h0, qcnt}, 32'h0);
        check_val("ar_req0", {31'h0, req}, 32'h0);
        check_val("ar_pc4", pc4, 32'h0);
        #1 rst_n = 1'b1;
        stall = 1'b0;
        cycle();
        check_val("ar_late_valid", {31'h0, valid}, 32'h0);
        check_val("ar_late_count", {29'h0, qcnt}, 32'h0);
        check_val("ar_restart_addr", addr, 32'h0);
        check_val("ar_restart_req", {31'h0, req}, 32'h1);
        cycle();
        check_val("ar_restart_inst", inst, wd(32'h0));
        check_val("ar_restart_pc4", pc4, 32'h4);

        // PC wrap from a reset PC near the top of the address space
        rst_w = 1'b1;
        cycle();
        check_val("wrap_addr0", addr_w, 32'hFFFF_FFF8);
        cycle();
        check_val("wrap_inst0", inst_w, wd(32'hFFFF_FFF8));
        check_val("wrap_pc4_0", pc4_w, 32'hFFFF_FFFC);
        check_val("wrap_addr1", addr_w, 32'hFFFF_FFFC);
        cycle();
        check_val("wrap_pc4_1", pc4_w, 32'h0000_0000);
        check_val("wrap_addr2", addr_w, 32'h0000_0000);
        cycle();
        check_val("wrap_pc4_2", pc4_w, 32'h0000_0004);
        check_val("wrap_valid", {31'h0, valid_w}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
